hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline.
- Forwarding resolves ALU-to-ALU dependences. This block handles the cases forwarding cannot resolve:
  - load-use dependences,
  - data-memory wait states,
  - taken-branch redirects.
- It sits beside the forwarding logic and drives the stall and flush enables of the PC and the pipeline registers.
- It also keeps a memory-wait timeout watchdog and a saturating stall-cycle counter.

Parameters:
- REGFILE_ADDR_WIDTH, 5, register-file address width.
- MEM_TIMEOUT, 64, number of consecutive memory-wait cycles before a timeout is declared (range 1..255).
- CNT_WIDTH, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_Rs1_addr  in  REGFILE_ADDR_WIDTH  rs1 of the instruction in ID.
- ID_Rs2_addr  in  REGFILE_ADDR_WIDTH  rs2 of the instruction in ID.
- ID_Rs1_used  in  1  instruction in ID reads rs1.
- ID_Rs2_used  in  1  instruction in ID reads rs2.
- EX_Rd_addr  in  REGFILE_ADDR_WIDTH  rd of the instruction in EX.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Branch_taken  in  1  branch/jump resolved taken in EX.
- MEM_req  in  1  load/store present in MEM.
- MEM_ready  in  1  data memory completes the access this cycle.
- PC_stall  out  1  hold PC.
- IF_ID_stall  out  1  hold IF/ID register.
- IF_ID_flush  out  1  load bubble into IF/ID.
- ID_EX_stall  out  1  hold ID/EX register.
- ID_EX_flush  out  1  load bubble into ID/EX.
- EX_MEM_stall  out  1  hold EX/MEM register.
- MEM_WB_flush  out  1  load bubble into MEM/WB.
- mem_timeout  out  1  sticky timeout flag.
- stall_cycles  out  CNT_WIDTH  count of cycles with PC_stall=1, saturating.

Behaviour:

FSM states: RUN, MEM_WAIT, TIMEOUT. Reset state is RUN.
- While rst_n=0:
  - all stall/flush outputs = 0;
  - mem_timeout = 0;
  - stall_cycles = 0;
  - wait counter = 0.

Condition terms:
- memwait = MEM_req & ~MEM_ready.
- loaduse = EX_MemRead & (EX_Rd_addr != 0) & ((ID_Rs1_used & EX_Rd_addr == ID_Rs1_addr) | (ID_Rs2_used & EX_Rd_addr == ID_Rs2_addr)).

Output priority, combinational from state and inputs, zero latency (highest first):
1. State TIMEOUT: PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall = 1; MEM_WB_flush = 1; all other outputs 0.
2. memwait (state RUN or MEM_WAIT): PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall = 1; MEM_WB_flush = 1. A pending branch or load-use in EX/ID is frozen and handled once memwait clears.
3. EX_Branch_taken: IF_ID_flush = 1 and ID_EX_flush = 1 for that single cycle; no stall. The PC redirect is driven by the branch unit. Branch wins over load-use because the ID instruction is squashed.
4. loaduse: PC_stall = 1, IF_ID_stall = 1, ID_EX_flush = 1 for exactly one cycle. On the next edge the load moves to MEM, so the condition clears naturally.
5. Otherwise all stall/flush outputs are 0.

FSM transitions:
- RUN -> MEM_WAIT when memwait. Wait counter is set to 1.
- MEM_WAIT, memwait still true: counter increments.
- MEM_WAIT -> TIMEOUT when memwait and counter == MEM_TIMEOUT-1 (i.e. MEM_TIMEOUT consecutive wait cycles). mem_timeout is registered and goes to 1 on that edge.
- MEM_WAIT -> RUN when MEM_ready=1. Counter clears.
- TIMEOUT is terminal until rst_n=0. mem_timeout stays 1.
- MEM_TIMEOUT=1: the first wait cycle transitions directly from RUN to TIMEOUT.

stall_cycles:
- Increments on every clock edge where PC_stall=1.
- Saturates at all-ones and does not wrap.

Reset mid-wait: asserting rst_n=0 immediately returns all outputs to 0 and the FSM to RUN, asynchronously.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd_addr=5, ID_Rs2_addr=5, ID_Rs2_used=1 -> exactly one cycle of PC_stall=IF_ID_stall=ID_EX_flush=1; stall_cycles goes 0->1.
- x0 and unused operands:
  - EX_MemRead=1, EX_Rd_addr=0, ID_Rs1_addr=0, ID_Rs1_used=1 -> no stall.
  - EX_MemRead=1, EX_Rd_addr=7, ID_Rs1_addr=7, ID_Rs1_used=0 -> no stall.
- Memory wait: MEM_req=1, MEM_ready=0 for 3 cycles, then MEM_ready=1:
  - 3 cycles of PC_stall=EX_MEM_stall=MEM_WB_flush=1, then all stall/flush outputs 0;
  - stall_cycles=3;
  - FSM returns to RUN.
- Branch and load-use together: EX_Branch_taken=1 while loaduse is true -> IF_ID_flush=ID_EX_flush=1 and PC_stall=0. Branch during memwait -> only the memwait stall appears until MEM_ready=1; the flush appears the cycle after.
- Timeout: with MEM_TIMEOUT=4, hold memwait for 6 cycles:
  - mem_timeout rises after the 4th wait cycle;
  - stalls stay asserted even after MEM_ready=1;
  - pulsing rst_n=0 clears the flag and all outputs.
- Counter saturation: with CNT_WIDTH=4, stall 20 cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush controller for a 5-stage RV32I pipeline. Handles
//               load-use hazards, data-memory wait states, taken-branch
//               redirects, a memory-wait timeout watchdog and a saturating
//               stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT        = 64,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
  input  logic                          ID_Rs1_used,
  input  logic                          ID_Rs2_used,
  input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
  input  logic                          EX_MemRead,
  input  logic                          EX_Branch_taken,
  input  logic                          MEM_req,
  input  logic                          MEM_ready,
  output logic                          PC_stall,
  output logic                          IF_ID_stall,
  output logic                          IF_ID_flush,
  output logic                          ID_EX_stall,
  output logic                          ID_EX_flush,
  output logic                          EX_MEM_stall,
  output logic                          MEM_WB_flush,
  output logic                          mem_timeout,
  output logic [CNT_WIDTH-1:0]          stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  // Wait counter value on the cycle that completes the timeout window.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       memwait;
  logic       loaduse;
  logic       rs1_hit;
  logic       rs2_hit;

  assign memwait = MEM_req & ~MEM_ready;
  assign rs1_hit = ID_Rs1_used & (EX_Rd_addr == ID_Rs1_addr);
  assign rs2_hit = ID_Rs2_used & (EX_Rd_addr == ID_Rs2_addr);
  assign loaduse = EX_MemRead & (EX_Rd_addr != '0) & (rs1_hit | rs2_hit);

  // Prioritised stall/flush decode; forced quiet while reset is held.
  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (!rst_n) begin
      PC_stall = 1'b0;
    end else if ((state == TIMEOUT) || memwait) begin
      // Freeze everything up to EX/MEM; bubble into MEM/WB.
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (EX_Branch_taken) begin
      // The ID instruction is squashed, so any load-use on it is moot.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (loaduse) begin
      // One bubble; the load reaches MEM on the next edge.
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end
  end

  // Memory-wait FSM with timeout watchdog and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memwait) begin
            if (MEM_TIMEOUT == 1) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= 8'd1;
            end
          end
        end
        MEM_WAIT: begin
          if (memwait) begin
            if (wait_cnt == WAIT_LAST) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end
        end
        TIMEOUT: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (PC_stall && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4,
//               CNT_WIDTH=4 so timeout and saturation are reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  // Output vector order: PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
  // ID_EX_flush, EX_MEM_stall, MEM_WB_flush.
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_MEM  = 7'b1101011;
  localparam logic [6:0] O_BR   = 7'b0010100;
  localparam logic [6:0] O_LU   = 7'b1100100;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ID_Rs1_addr, ID_Rs2_addr, EX_Rd_addr;
  logic          ID_Rs1_used, ID_Rs2_used, EX_MemRead, EX_Branch_taken;
  logic          MEM_req, MEM_ready;
  logic          PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
  logic          EX_MEM_stall, MEM_WB_flush, mem_timeout;
  logic [CW-1:0] stall_cycles;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .REGFILE_ADDR_WIDTH(AW),
    .MEM_TIMEOUT       (4),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_Rs1_addr    (ID_Rs1_addr),
    .ID_Rs2_addr    (ID_Rs2_addr),
    .ID_Rs1_used    (ID_Rs1_used),
    .ID_Rs2_used    (ID_Rs2_used),
    .EX_Rd_addr     (EX_Rd_addr),
    .EX_MemRead     (EX_MemRead),
    .EX_Branch_taken(EX_Branch_taken),
    .MEM_req        (MEM_req),
    .MEM_ready      (MEM_ready),
    .PC_stall       (PC_stall),
    .IF_ID_stall    (IF_ID_stall),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_stall    (ID_EX_stall),
    .ID_EX_flush    (ID_EX_flush),
    .EX_MEM_stall   (EX_MEM_stall),
    .MEM_WB_flush   (MEM_WB_flush),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles)
  );

  assign outs = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
                 ID_EX_flush, EX_MEM_stall, MEM_WB_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_Rs1_addr = '0; ID_Rs2_addr = '0; EX_Rd_addr = '0;
    ID_Rs1_used = 1'b0; ID_Rs2_used = 1'b0; EX_MemRead = 1'b0;
    EX_Branch_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
  endtask

  // Advance one clock edge and return to the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, check everything clears asynchronously.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_outs"}, {25'd0, outs}, {25'd0, O_NONE});
    check({tag, "_tmo"}, {31'd0, mem_timeout}, 32'd0);
    check({tag, "_cnt"}, {28'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_outs", {25'd0, outs}, {25'd0, O_NONE});
    check("rst_tmo", {31'd0, mem_timeout}, 32'd0);
    check("rst_cnt", {28'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_outs", {25'd0, outs}, {25'd0, O_NONE});

    // Load-use on rs2: one bubble, counter 0 -> 1.
    EX_MemRead = 1'b1; EX_Rd_addr = 5'd5; ID_Rs2_addr = 5'd5; ID_Rs2_used = 1'b1;
    #1;
    check("lu_outs", {25'd0, outs}, {25'd0, O_LU});
    check("lu_cnt0", {28'd0, stall_cycles}, 32'd0);
    step();
    idle();
    #1;
    check("lu_after", {25'd0, outs}, {25'd0, O_NONE});
    check("lu_cnt1", {28'd0, stall_cycles}, 32'd1);

    // x0 destination never stalls.
    EX_MemRead = 1'b1; EX_Rd_addr = 5'd0; ID_Rs1_addr = 5'd0; ID_Rs1_used = 1'b1;
    #1;
    check("x0_outs", {25'd0, outs}, {25'd0, O_NONE});
    // Matching but unused operand never stalls.
    EX_Rd_addr = 5'd7; ID_Rs1_addr = 5'd7; ID_Rs1_used = 1'b0;
    #1;
    check("unused_outs", {25'd0, outs}, {25'd0, O_NONE});
    // Load-use via rs1.
    ID_Rs1_used = 1'b1;
    #1;
    check("lu_rs1_outs", {25'd0, outs}, {25'd0, O_LU});
    idle();
    step();
    check("lu_rs1_cnt", {28'd0, stall_cycles}, 32'd1);

    reset_pulse("rst1");
    step();

    // Memory wait of three cycles, then ready.
    MEM_req = 1'b1; MEM_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("mw_outs", {25'd0, outs}, {25'd0, O_MEM});
      step();
    end
    MEM_ready = 1'b1;
    #1;
    check("mw_ready_outs", {25'd0, outs}, {25'd0, O_NONE});
    check("mw_cnt", {28'd0, stall_cycles}, 32'd3);
    step();
    idle();
    // Back in RUN: a fresh load-use still works.
    EX_MemRead = 1'b1; EX_Rd_addr = 5'd9; ID_Rs1_addr = 5'd9; ID_Rs1_used = 1'b1;
    #1;
    check("mw_run_lu", {25'd0, outs}, {25'd0, O_LU});
    step();
    check("mw_run_cnt", {28'd0, stall_cycles}, 32'd4);

    // Branch together with load-use: flush wins, no stall.
    EX_Branch_taken = 1'b1;
    #1;
    check("br_lu_outs", {25'd0, outs}, {25'd0, O_BR});
    step();
    check("br_lu_cnt", {28'd0, stall_cycles}, 32'd4);
    idle();

    // Branch during memwait: only stall until ready, then the flush.
    EX_Branch_taken = 1'b1; MEM_req = 1'b1; MEM_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      #1;
      check("br_mw_outs", {25'd0, outs}, {25'd0, O_MEM});
      step();
    end
    MEM_ready = 1'b1;
    #1;
    check("br_mw_flush", {25'd0, outs}, {25'd0, O_BR});
    step();
    idle();
    #1;
    check("br_mw_done", {25'd0, outs}, {25'd0, O_NONE});
    check("br_mw_cnt", {28'd0, stall_cycles}, 32'd6);

    reset_pulse("rst2");

    // Timeout: six wait cycles, flag rises after the fourth.
    MEM_req = 1'b1; MEM_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      check("to_outs", {25'd0, outs}, {25'd0, O_MEM});
      check("to_flag", {31'd0, mem_timeout}, (i >= 5) ? 32'd1 : 32'd0);
      step();
    end
    MEM_ready = 1'b1;
    #1;
    check("to_ready_outs", {25'd0, outs}, {25'd0, O_MEM});
    step();
    check("to_cnt", {28'd0, stall_cycles}, 32'd7);
    MEM_req = 1'b0;
    #1;
    check("to_noreq_outs", {25'd0, outs}, {25'd0, O_MEM});
    check("to_sticky", {31'd0, mem_timeout}, 32'd1);
    MEM_req = 1'b1; MEM_ready = 1'b0;
    reset_pulse("rst3");

    // Saturation: twenty stalled edges, counter parks at 15.
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) check("sat_14", {28'd0, stall_cycles}, 32'd14);
      if (i == 15) check("sat_15", {28'd0, stall_cycles}, 32'd15);
    end
    check("sat_20", {28'd0, stall_cycles}, 32'd15);
    reset_pulse("rst4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
